// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a qualified
// bit stream and holds each word under a valid/ready handshake.
module shift_deser #(
    parameter int WIDTH     = 32,
    parameter int MSB_FIRST = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_shift,
    input  logic                     i_shift_en,
    input  logic                     i_frame,
    input  logic                     i_ready,
    input  logic                     i_clr_ovf,
    output logic [WIDTH-1:0]         o_word,
    output logic                     o_valid,
    output logic                     o_overflow,
    output logic [$clog2(WIDTH)-1:0] o_bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    always_comb begin
        // A frame strobe restarts from an empty register before shifting.
        base = i_frame ? '0 : sreg_q;
        if (MSB_FIRST != 0) begin
            shifted = {base[WIDTH-2:0], i_shift};
        end else begin
            shifted = {i_shift, base[WIDTH-1:1]};
        end
        complete = i_shift_en && !i_frame && (cnt_q == LAST_BIT);
    end

    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;

        if (i_shift_en) begin
            sreg_d = shifted;
            if (i_frame) begin
                cnt_d = CW'(1);
            end else if (complete) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (i_frame) begin
            sreg_d = '0;
            cnt_d  = '0;
        end

        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end

        // A finished word either refills the holding register or is dropped.
        if (complete) begin
            if (!valid_q || i_ready) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sreg_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_word     = word_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;
    assign o_bit_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_deser.sv
// Bench for shift_deser: MSB-first and LSB-first instances share one stream,
// checked by a bit-queue reference model and a word scoreboard.
module tb_shift_deser;

    localparam int W = 8;

    logic clk;
    logic rst, sh, en, fr, rdy, clr;

    logic [W-1:0] m_word, l_word;
    logic         m_valid_o, l_valid_o;
    logic         m_ovf_o, l_ovf_o;
    logic [2:0]   m_cnt_o, l_cnt_o;

    shift_deser #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .i_clk(clk), .i_reset(rst), .i_shift(sh), .i_shift_en(en),
        .i_frame(fr), .i_ready(rdy), .i_clr_ovf(clr),
        .o_word(m_word), .o_valid(m_valid_o), .o_overflow(m_ovf_o),
        .o_bit_cnt(m_cnt_o)
    );

    shift_deser #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .i_clk(clk), .i_reset(rst), .i_shift(sh), .i_shift_en(en),
        .i_frame(fr), .i_ready(rdy), .i_clr_ovf(clr),
        .o_word(l_word), .o_valid(l_valid_o), .o_overflow(l_ovf_o),
        .o_bit_cnt(l_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // Reference model: partial word kept as a list of received bits.
    bit           bits[$];
    bit           md_valid;
    bit           md_ovf;
    logic [W-1:0] exp_m[$];
    logic [W-1:0] exp_l[$];
    logic [W-1:0] wm, wl;
    bit           loaded;

    always @(posedge clk) begin
        if (rst) begin
            bits.delete();
            md_valid = 0;
            md_ovf   = 0;
            exp_m.delete();
            exp_l.delete();
        end else begin
            loaded = 0;
            if (clr) md_ovf = 0;
            if (fr) bits.delete();
            if (en) begin
                bits.push_back(sh);
                if (!fr && bits.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = bits[i];
                        wl[i]     = bits[i];
                    end
                    bits.delete();
                    if (!md_valid || rdy) begin
                        exp_m.push_back(wm);
                        exp_l.push_back(wl);
                        loaded = 1;
                    end else begin
                        md_ovf = 1;
                    end
                end
            end
            if (loaded) md_valid = 1;
            else if (md_valid && rdy) md_valid = 0;
        end
    end

    // Monitor: compares held words and status, retires consumed words.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_m", m_valid_o, md_valid);
            chk("valid_l", l_valid_o, md_valid);
            chk("ovf_m", m_ovf_o, md_ovf);
            chk("ovf_l", l_ovf_o, md_ovf);
            chk("cnt_m", m_cnt_o, bits.size());
            chk("cnt_l", l_cnt_o, bits.size());
            if (md_valid) begin
                if (exp_m.size() == 0 || exp_l.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    chk("word_m", m_word, exp_m[0]);
                    chk("word_l", l_word, exp_l[0]);
                    if (rdy) begin
                        void'(exp_m.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic s, input logic e,
                       input logic f, input logic y, input logic c);
        rst = r; sh = s; en = e; fr = f; rdy = y; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input logic frame_first,
                        input logic rdy_mid, input logic rdy_last);
        for (int i = 0; i < W; i++)
            cyc(0, w[W-1-i], 1, frame_first && i == 0,
                (i == W-1) ? rdy_last : rdy_mid, 0);
    endtask

    initial begin
        rst = 1; sh = 0; en = 0; fr = 0; rdy = 0; clr = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0);
        chk("rst_word", m_word, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_ovf", m_ovf_o, 0);
        chk("rst_cnt", m_cnt_o, 0);

        send(8'hA5, 1, 1, 1);
        chk("a5_valid", m_valid_o, 1);
        chk("a5_m", m_word, 8'hA5);
        chk("a5_l", l_word, 8'hA5);
        chk("a5_cnt", m_cnt_o, 0);
        cyc(0, 0, 0, 0, 1, 0);

        send(8'h80, 1, 1, 1);
        chk("one_m", m_word, 8'h80);
        chk("one_l", l_word, 8'h01);
        cyc(0, 0, 0, 0, 1, 0);

        send(8'h3C, 1, 0, 0);
        send(8'hC3, 1, 0, 0);
        chk("ovf_word", m_word, 8'h3C);
        chk("ovf_word_l", l_word, 8'h3C);
        chk("ovf_valid", m_valid_o, 1);
        chk("ovf_set", m_ovf_o, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("ovf_clr", m_ovf_o, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("drain", m_valid_o, 0);

        send(8'h12, 1, 0, 0);
        send(8'h34, 1, 0, 1);
        chk("b2b_ovf", m_ovf_o, 0);
        chk("b2b_word", m_word, 8'h34);
        chk("b2b_word_l", l_word, rev(8'h34));
        chk("b2b_valid", m_valid_o, 1);
        cyc(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < W-1; i++) cyc(0, 1, 1, i == 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        chk("fw_cnt", m_cnt_o, 1);
        chk("fw_valid", m_valid_o, 0);
        for (int i = 0; i < W-1; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("fw_m", m_word, 8'h80);
        chk("fw_l", l_word, 8'h01);
        cyc(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0);
        chk("part_cnt", m_cnt_o, 5);
        cyc(0, 0, 0, 1, 0, 0);
        chk("frm_cnt", m_cnt_o, 0);
        send(8'h5A, 0, 0, 0);
        chk("5a_m", m_word, 8'h5A);
        chk("5a_l", l_word, 8'h5A);
        cyc(0, 0, 0, 0, 1, 0);

        send(8'h11, 1, 0, 0);
        send(8'h22, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0, 0);
        chk("pre_cnt", m_cnt_o, 4);
        chk("pre_ovf", m_ovf_o, 1);
        cyc(1, 1, 1, 0, 0, 0);
        chk("r2_word", m_word, 0);
        chk("r2_word_l", l_word, 0);
        chk("r2_valid", m_valid_o, 0);
        chk("r2_ovf", m_ovf_o, 0);
        chk("r2_cnt", m_cnt_o, 0);
        send(8'h96, 0, 0, 0);
        chk("96_m", m_word, 8'h96);
        chk("96_l", l_word, 8'h69);
        cyc(0, 0, 0, 0, 1, 0);

        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(99) == 0, 1'($urandom),
                $urandom_range(9) < 7, $urandom_range(19) == 0,
                1'($urandom), $urandom_range(19) == 0);
        cyc(0, 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-to-parallel receiver: the counterpart to the team's parallel-load, MSB-first shift-out register.
- Accepts one qualified serial bit per cycle and assembles WIDTH-bit words.
- Presents each complete word in a holding register under a valid/ready handshake.
- Sits at the receive end of the serial links inside the interconnect test harness; detects and flags words lost to back-pressure.

Parameters:
- WIDTH, 32, word width in bits; legal range >= 2.
- MSB_FIRST, 1, bit order. 1: first received bit lands in o_word[WIDTH-1]. 0: first received bit lands in o_word[0].

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_shift  input  1  serial data bit.
- i_shift_en  input  1  i_shift is valid this cycle.
- i_frame  input  1  word-alignment strobe: this cycle starts a new word.
- i_ready  input  1  consumer accepts o_word this cycle.
- i_clr_ovf  input  1  clears o_overflow.
- o_word  output  WIDTH  last completed word.
- o_valid  output  1  o_word holds an unconsumed word.
- o_overflow  output  1  sticky: a completed word was dropped.
- o_bit_cnt  output  clog2(WIDTH)  bits collected in the current partial word.

Behaviour:
- Reset (i_reset high at a rising edge; takes priority over all other inputs, including mid-word):
  - shift register, o_word, o_bit_cnt cleared to 0.
  - o_valid = 0, o_overflow = 0.
- Shifting, on each edge with i_shift_en = 1:
  - MSB_FIRST = 1: sreg <= {sreg[WIDTH-2:0], i_shift}.
  - MSB_FIRST = 0: sreg <= {i_shift, sreg[WIDTH-1:1]}.
  - o_bit_cnt increments.
  - i_shift_en = 0: sreg and o_bit_cnt hold; gaps of any length are legal.
- Word completion: i_shift_en = 1 and o_bit_cnt = WIDTH-1.
  - Assembled word = sreg shifted with the current i_shift. It is formed combinationally and written to o_word at that same edge.
  - o_bit_cnt wraps to 0.
  - Latency: o_word/o_valid change at the edge that samples the last bit, so they are visible the following cycle.
- Handshake:
  - o_valid stays high until an edge with i_ready = 1.
  - o_word is stable while o_valid = 1, except for the reload case below.
  - i_ready while o_valid = 0 has no effect.
- Completion while o_valid = 1:
  - With i_ready = 1 (same cycle): old word consumed, new word loaded, o_valid stays 1; no overflow.
  - With i_ready = 0: new word discarded, o_word keeps the old word, o_overflow <= 1.
- o_overflow:
  - Sticky; cleared only by i_reset or i_clr_ovf.
  - If i_clr_ovf and a new overflow occur at the same edge, set wins (o_overflow = 1).
- i_frame = 1:
  - Partial word discarded; o_bit_cnt restarts.
  - With i_shift_en = 1 in the same cycle: current bit becomes bit 0 of the new word, o_bit_cnt <= 1, sreg cleared then shifted.
    - Exception: if WIDTH-1 bits were already collected, no completion occurs; the frame wins.
  - With i_shift_en = 0: o_bit_cnt <= 0, sreg <= 0.
  - Does not affect o_word, o_valid or o_overflow.
- Unused sreg bits of a partial word are don't-care, but must read 0 after reset/frame for verification.

Test Plan:
- WIDTH=8, MSB_FIRST=1, i_ready=1: frame + 8 bits 1,0,1,0,0,1,0,1 on consecutive cycles -> o_valid high 1 cycle after the last bit, o_word=8'hA5, o_bit_cnt back to 0.
- Same stream with MSB_FIRST=0 -> o_word=8'hA5 bit-reversed = 8'hA5 (palindrome). Then send 8'h01 pattern (1 then seven 0s) -> o_word=8'h01 (MSB_FIRST=0) vs 8'h80 (MSB_FIRST=1).
- i_ready=0; send 8'h3C then 8'hC3 -> o_word stays 8'h3C, o_valid=1, o_overflow=1. Pulse i_clr_ovf -> o_overflow=0. Raise i_ready -> o_valid=0 next cycle.
- Back-to-back words with i_ready asserted only on the completion cycle of word 2 -> no overflow, o_word=word 2, o_valid stays 1.
- 5 bits shifted, then i_frame with i_shift_en=0, then 8 bits of 8'h5A -> o_word=8'h5A; o_bit_cnt reads 5 before the frame and 0 after it.
- i_reset asserted after 4 bits with o_valid=1 and o_overflow=1 -> next cycle all outputs 0. Fresh 8 bits give a correct word.
